mac_pipe_ctrl: RTL

Sequencer for the convolution MAC datapath pipeline. It accepts a job (output-window count × accumulations per window), admits input beats under a valid/ready handshake, and drives per-stage load enables for the datapath flip-flop stages. It also tags the first and last beat of each accumulation group and presents a held output-valid to the downstream consumer. It sits between the input window fetcher and the multiply/accumulate register chain, and owns all stall and drain decisions for that chain.

---
 rtl/mac_pipe_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_pipe_ctrl.sv
// mac_pipe_ctrl
// Sequencer for the convolution MAC datapath pipeline. It takes a job of
// cfg_windows output windows of cfg_acc beats each. It admits beats under
// in_valid/in_ready and walks a valid vector down the datapath register
// stages, driving one load enable per stage. It tags the first and last beat
// of each accumulation group as that beat loads the accumulator (last stage).
// It also holds out_valid until downstream takes the finished window. A
// pending window that downstream refuses stalls the whole chain.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : job start pulse, honoured only when idle
//   cfg_windows/cfg_acc : job shape, sampled on an accepted start
//   in_valid/in_ready   : upstream beat handshake
//   stage_en            : per-stage datapath load enables
//   acc_first/acc_last  : group tags of the beat loading the accumulator
//   out_valid/out_ready : finished-window handshake to downstream
//   busy, done          : job in progress / one-cycle completion pulse
//   perf_stall          : stalled-with-work cycle counter (optional)
//
// Optional feature: define MAC_PIPE_CTRL_PERF_EN to add perf_stall.

module mac_pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_windows,
  input  logic [ACC_W-1:0]  cfg_acc,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [STAGES-1:0] stage_en,
  output logic              acc_first,
  output logic              acc_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef MAC_PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cfg_win_q, cfg_win_d;
  logic [ACC_W-1:0]  cfg_acc_q, cfg_acc_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [STAGES-1:0] v_q, v_d;
  // Tags only need to travel as far as the stage feeding the accumulator.
  logic [STAGES-2:0] first_q, first_d;
  logic [STAGES-2:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;

  logic              stall;
  logic              run_ready;
  logic              accept;
  logic              beat_first;
  logic              beat_last;
  logic              load_last;
  logic [STAGES-1:0] en;

  always_comb begin
    stall      = out_valid_q & ~out_ready;
    run_ready  = (state_q == S_RUN) & ~stall;
    accept     = in_valid & run_ready;
    beat_first = (beat_cnt_q == '0);
    beat_last  = (beat_cnt_q == cfg_acc_q - ACC_ONE);
    en         = '0;
    en[0]      = accept;
    for (int i = 1; i < STAGES; i++) begin
      en[i] = v_q[i-1] & ~stall;
    end
    load_last  = en[STAGES-1] & last_q[STAGES-2];
  end

  always_comb begin
    // NOTE: every signal written in this block gets its hold value first, so
    // no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    cfg_win_d   = cfg_win_q;
    cfg_acc_d   = cfg_acc_q;
    win_cnt_d   = win_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    v_d         = v_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    // The whole chain freezes while a finished window waits downstream.
    if (!stall) begin
      v_d        = {v_q[STAGES-2:0], accept};
      first_d[0] = accept & beat_first;
      last_d[0]  = accept & beat_last;
      for (int i = 1; i <= STAGES - 2; i++) begin
        first_d[i] = first_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end

    // A new window landing wins over the take of the previous one.
    if (load_last) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_win_d  = cfg_windows;
          cfg_acc_d  = cfg_acc;
          win_cnt_d  = '0;
          beat_cnt_d = '0;
          // An empty job goes through DRAIN, which closes at once on the
          // empty pipe, so done still follows start by two cycles.
          if (cfg_windows == '0 || cfg_acc == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          if (beat_last) begin
            beat_cnt_d = '0;
            win_cnt_d  = win_cnt_q + CNT_ONE;
            if (win_cnt_q == cfg_win_q - CNT_ONE) begin
              state_d = S_DRAIN;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + ACC_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (v_q == '0 && (!out_valid_q || out_ready)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      cfg_win_q   <= '0;
      cfg_acc_q   <= '0;
      win_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      v_q         <= '0;
      first_q     <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_win_q   <= cfg_win_d;
      cfg_acc_q   <= cfg_acc_d;
      win_cnt_q   <= win_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      v_q         <= v_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: outputs are masked by reset combinationally so a mid-job reset
  // silences the datapath in the reset cycle itself, not one cycle later.
  assign in_ready  = run_ready & ~reset;
  assign stage_en  = en & {STAGES{~reset}};
  assign acc_first = en[STAGES-1] & first_q[STAGES-2] & ~reset;
  assign acc_last  = en[STAGES-1] & last_q[STAGES-2] & ~reset;
  assign out_valid = out_valid_q & ~reset;
  assign busy      = (state_q != S_IDLE) & ~reset;
  assign done      = (state_q == S_DONE) & ~reset;

`ifdef MAC_PIPE_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start) begin
      perf_d = '0;
    end else if (stall && v_q != '0 && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q;
`endif

endmodule
